dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the single read/write port of the CPU data memory. It lets the CPU load/store path and the debug/PDU host port share that port. The block grants one transaction at a time, round-robin, and drives the memory's address, write data, write control and read control. It returns read data and a completion pulse to the winning requester. It sits between the CPU/debug logic and the data memory; the memory's separate read-only debug port is untouched.

## Interface
- ADDR_W, 10, byte address width (memory word index is addr[ADDR_W-1:2])
- DATA_W, 32, data width
- clk  in  1  clock; memory writes also commit on its rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_req / dbg_req  in  1  request, held high until ready seen
- cpu_ready / dbg_ready  out  1  request accepted this cycle (reset 0)
- cpu_addr / dbg_addr  in  ADDR_W  byte address
- cpu_wdata / dbg_wdata  in  DATA_W  store data
- cpu_we / dbg_we  in  2  0 none, 1 word, 2 half, 3 byte
- cpu_rd_ctrl / dbg_rd_ctrl  in  3  0 none, 1 lw, 2 lhu, 3 lh, 4 lbu, 5 lb
- cpu_rvalid / dbg_rvalid  out  1  one-cycle completion pulse (reset 0)
- cpu_rdata / dbg_rdata  out  DATA_W  result, valid with rvalid (reset 0)
- dm_a  out  ADDR_W  memory address (reset 0)
- dm_d  out  DATA_W  memory write data (reset 0)
- dm_we  out  2  memory write control (reset 0)
- dm_rd_ctrl  out  3  memory read control (reset 0)
- dm_spo  in  DATA_W  combinational memory read data

## Operation
- FSM states: IDLE, ACCESS, RESP; reset state is IDLE.
- IDLE
  - Any request triggers a grant: winner's ready is high combinationally this cycle.
  - Winner's addr, wdata, we and rd_ctrl are latched; the winner's id is latched; FSM goes to ACCESS.
- ACCESS
  - dm_* outputs are driven from the latched fields.
  - If latched we != 0, dm_rd_ctrl is forced to 0; a write takes priority over a read.
  - dm_spo is registered into the result register; FSM goes to RESP.
- RESP
  - Winner's rvalid = 1; its rdata = registered result (0 for writes).
  - The other requester's rdata holds its previous value.
  - FSM goes to IDLE.
- A transaction with we = 0 and rd_ctrl = 0 is legal: no memory effect, rdata = 0, rvalid still pulses.
- Outside ACCESS: dm_we = 0 and dm_rd_ctrl = 0; dm_a and dm_d hold their last values.
- dm_we is gated by !rst, so no write commits on an edge where rst is high.
- Arbitration:
  - A last-grant register resets to dbg.
  - If only one requester is active, it wins.
  - If both are active, the one not granted last wins; last-grant updates on each grant.
- No alignment checking: misaligned addresses pass through unchanged.
- rd_ctrl values 6–7 pass through; the memory returns 0.

## Timing
- Request seen in IDLE in cycle N, then:
  - ready in N
  - memory access in N+1 (write commits at the end of N+1)
  - rvalid in N+2
- Throughput is one transaction per 3 cycles.
- A requester holding req through RESP is re-arbitrated in the next IDLE cycle (N+3).
- Both requesters continuously active → strict alternation, each served every 6 cycles.
- req dropped before ready: withdrawn, no side effect.
- rst in any state:
  - next state IDLE; all outputs go to their reset values at the next edge.
  - A pending rvalid is never issued.
  - last-grant returns to dbg.

## Configuration
- DMEM_ARB_DBG_LOCK_EN defined:
  - Adds input dbg_lock (1 bit).
  - While dbg_lock = 1, cpu_req is ignored in IDLE.
  - A CPU transaction already past IDLE completes normally.
- Undefined: port absent; pure round-robin.

## Structure
- Package dmem_arb_pkg holds:
  - state encoding (IDLE = 0, ACCESS = 1, RESP = 2)
  - we encodings WE_NONE/WORD/HALF/BYTE
  - rd_ctrl encodings RD_NONE/LW/LHU/LH/LBU/LB
  - requester ids REQ_CPU = 0, REQ_DBG = 1
- Sub-module rr_arb2: combinational two-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt one-hot, gnt_id.
- Everything else (FSM, latches, muxes) lives in dmem_arbiter.

## Test plan
- CPU word write addr 0x010, data 0xDEADBEEF, we = 1, then lw at 0x010 → write rvalid at N+2 with rdata 0; read rvalid returns 0xDEADBEEF; dm_we high for exactly one cycle.
- dbg byte write we = 3, addr 0x013, data 0x80, then CPU lb at 0x013 → cpu_rdata = 0xFFFFFF80; lbu → 0x00000080.
- cpu_req and dbg_req asserted together from reset, held for 12 cycles → grants in order CPU, DBG, CPU, DBG; ready cycles 0, 3, 6, 9.
- rst asserted during ACCESS of a dbg write to 0x020 → word 0x020 unchanged; no dbg_rvalid; all outputs 0 at the next edge.
- Read with rd_ctrl = 0 and we = 0 at 0x000 → rvalid pulses with rdata 0; dm_we and dm_rd_ctrl stay 0 throughout.
- With DMEM_ARB_DBG_LOCK_EN: dbg_lock = 1 and cpu_req held → no cpu_ready; dbg requests still served; cpu_ready asserts the cycle after dbg_lock falls (FSM in IDLE).

Source files
------------

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared encodings for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] WE_NONE = 2'd0;
    localparam logic [1:0] WE_WORD = 2'd1;
    localparam logic [1:0] WE_HALF = 2'd2;
    localparam logic [1:0] WE_BYTE = 2'd3;

    localparam logic [2:0] RD_NONE = 3'd0;
    localparam logic [2:0] RD_LW   = 3'd1;
    localparam logic [2:0] RD_LHU  = 3'd2;
    localparam logic [2:0] RD_LH   = 3'd3;
    localparam logic [2:0] RD_LBU  = 3'd4;
    localparam logic [2:0] RD_LB   = 3'd5;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Combinational two-way round-robin picker (cpu = bit 0, dbg = bit 1).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt_id = REQ_CPU;
        gnt    = 2'b00;
        case (req)
            2'b01:   gnt_id = REQ_CPU;
            2'b10:   gnt_id = REQ_DBG;
            // Contention: whoever was not served last goes first.
            2'b11:   gnt_id = (last == REQ_CPU) ? REQ_DBG : REQ_CPU;
            default: gnt_id = REQ_CPU;
        endcase
        if (req != 2'b00) begin
            gnt = (gnt_id == REQ_DBG) ? 2'b10 : 2'b01;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin sharing of the data-memory port between the CPU and
//            the debug host; optional DMEM_ARB_DBG_LOCK_EN adds dbg_lock.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DMEM_ARB_DBG_LOCK_EN
    input  logic              dbg_lock,
`endif
    input  logic              cpu_req,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_we,
    input  logic [2:0]        cpu_rd_ctrl,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    output logic              dbg_ready,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [1:0]        dbg_we,
    input  logic [2:0]        dbg_rd_ctrl,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] dm_a,
    output logic [DATA_W-1:0] dm_d,
    output logic [1:0]        dm_we,
    output logic [2:0]        dm_rd_ctrl,
    input  logic [DATA_W-1:0] dm_spo
);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_grant;
    logic                w_cpu_req;
    logic [1:0]          w_req;
    logic [1:0]          w_gnt;
    logic                w_gnt_id;
    logic                r_last;
    logic                r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_we;
    logic [2:0]          r_rd_ctrl;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_dbg_rdata;
    logic                r_cpu_rvalid;
    logic                r_dbg_rvalid;
    logic [DATA_W-1:0]   w_result;
    logic                w_in_access;

`ifdef DMEM_ARB_DBG_LOCK_EN
    assign w_cpu_req = cpu_req & ~dbg_lock;
`else
    assign w_cpu_req = cpu_req;
`endif
    assign w_req = {dbg_req, w_cpu_req};

    rr_arb2 u_rr_arb2 (
        .req    (w_req),
        .last   (r_last),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req != 2'b00) begin
                    w_grant      = 1'b1;
                    w_state_next = ACCESS;
                end
            end
            ACCESS:  w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign cpu_ready = w_grant & w_gnt[0] & ~rst;
    assign dbg_ready = w_grant & w_gnt[1] & ~rst;

    // Write strobe is masked by rst so a reset edge never commits a store.
    assign w_in_access = (r_state == ACCESS) & ~rst;
    assign dm_a        = r_addr;
    assign dm_d        = r_wdata;
    assign dm_we       = w_in_access ? r_we : WE_NONE;
    assign dm_rd_ctrl  = (w_in_access && r_we == WE_NONE) ? r_rd_ctrl : RD_NONE;

    // Writes and no-op transactions always report zero data.
    assign w_result = (r_we == WE_NONE && r_rd_ctrl != RD_NONE) ? dm_spo : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last       <= REQ_DBG;
            r_id         <= REQ_CPU;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= WE_NONE;
            r_rd_ctrl    <= RD_NONE;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
        end else begin
            if (w_grant) begin
                r_last    <= w_gnt_id;
                r_id      <= w_gnt_id;
                r_addr    <= (w_gnt_id == REQ_DBG) ? dbg_addr    : cpu_addr;
                r_wdata   <= (w_gnt_id == REQ_DBG) ? dbg_wdata   : cpu_wdata;
                r_we      <= (w_gnt_id == REQ_DBG) ? dbg_we      : cpu_we;
                r_rd_ctrl <= (w_gnt_id == REQ_DBG) ? dbg_rd_ctrl : cpu_rd_ctrl;
            end
            r_cpu_rvalid <= (r_state == ACCESS) && (r_id == REQ_CPU);
            r_dbg_rvalid <= (r_state == ACCESS) && (r_id == REQ_DBG);
            if (r_state == ACCESS) begin
                if (r_id == REQ_CPU) begin
                    r_cpu_rdata <= w_result;
                end else begin
                    r_dbg_rdata <= w_result;
                end
            end
        end
    end

    assign cpu_rvalid = r_cpu_rvalid;
    assign dbg_rvalid = r_dbg_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign dbg_rdata  = r_dbg_rdata;

endmodule : dmem_arbiter
`default_nettype wire
